// File: rtl/mv_row_sequencer.sv
`default_nettype none
// ============================================================================
// mv_row_sequencer : streams signed w*x products to an external
//                    adder-accumulator and returns one dot product per row.
// Revision: 1.0
// ============================================================================
module mv_row_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cfg_cols,
  input  logic [7:0]  cfg_rows,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  w_i,
  input  logic [7:0]  x_i,
  output logic [23:0] A_o,
  output logic        aac,
  input  logic [23:0] acc_i,
  output logic        row_valid,
  output logic [23:0] row_sum,
  output logic [7:0]  row_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [7:0]         r_last_col;
  logic [7:0]         r_last_row;
  logic [7:0]         r_col;
  logic [7:0]         r_row;
  logic               w_accept;
  logic               w_start_ok;
  logic               w_last_col;
  logic               w_last_row;
  logic signed [15:0] w_prod;
  logic               r_p1_vld;
  logic               r_p1_last;
  logic [7:0]         r_p1_idx;
  logic               r_p2_vld;
  logic               r_p2_last;
  logic [7:0]         r_p2_idx;

  assign w_accept   = in_valid & in_ready;
  assign w_start_ok = start & (r_state == S_IDLE);
  assign w_last_col = (r_col == r_last_col);
  assign w_last_row = (r_row == r_last_row);
  assign w_prod     = $signed(w_i) * $signed(x_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_ACCUM;
      S_ACCUM: if (w_accept && w_last_col && w_last_row) w_next_state = S_DRAIN;
      S_DRAIN: if (done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_ACCUM);
    busy     = (r_state != S_IDLE);
  end

  // Storing count-1 lets a zero config wrap naturally to 255 (i.e. 256 items).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_col <= 8'd0;
      r_last_row <= 8'd0;
      r_col      <= 8'd0;
      r_row      <= 8'd0;
    end else if (w_start_ok) begin
      r_last_col <= cfg_cols - 8'd1;
      r_last_row <= cfg_rows - 8'd1;
      r_col      <= 8'd0;
      r_row      <= 8'd0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= 8'd0;
        r_row <= r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // Idle cycles feed zero with accumulate set so the downstream sum holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A_o <= 24'd0;
      aac <= 1'b0;
    end else if (w_accept) begin
      A_o <= {{8{w_prod[15]}}, w_prod};
      aac <= (r_col != 8'd0);
    end else begin
      A_o <= 24'd0;
      aac <= 1'b1;
    end
  end

  // Row-end tracking: product lands at E0+1, sum is readable at E0+2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_vld  <= 1'b0;
      r_p1_last <= 1'b0;
      r_p1_idx  <= 8'd0;
      r_p2_vld  <= 1'b0;
      r_p2_last <= 1'b0;
      r_p2_idx  <= 8'd0;
      row_valid <= 1'b0;
      done      <= 1'b0;
      row_sum   <= 24'd0;
      row_idx   <= 8'd0;
    end else begin
      r_p1_vld  <= w_accept & w_last_col;
      r_p1_last <= w_last_row;
      r_p1_idx  <= r_row;
      r_p2_vld  <= r_p1_vld;
      r_p2_last <= r_p1_last;
      r_p2_idx  <= r_p1_idx;
      row_valid <= r_p2_vld;
      done      <= r_p2_vld & r_p2_last;
      if (r_p2_vld) begin
        row_sum <= acc_i;
        row_idx <= r_p2_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mv_row_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mv_row_sequencer : randomized scoreboard bench with an external
//                       adder-accumulator model.
// Revision: 1.0
// ============================================================================
module tb_mv_row_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, in_valid, in_ready, aac, row_valid, busy, done;
  logic [7:0]  cfg_cols, cfg_rows, w_i, x_i, row_idx;
  logic [23:0] A_o, acc_i, row_sum;

  always #5 clk = ~clk;

  mv_row_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_ready(in_ready), .w_i(w_i), .x_i(x_i),
    .A_o(A_o), .aac(aac), .acc_i(acc_i),
    .row_valid(row_valid), .row_sum(row_sum), .row_idx(row_idx),
    .busy(busy), .done(done)
  );

  // Downstream adder-accumulator
  logic [23:0] acc_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= aac ? acc_q + A_o : A_o;
  end
  assign acc_i = acc_q;

  typedef struct { int sum; int idx; bit last; int cyc; } row_t;
  typedef struct { logic [23:0] a; logic aac; } a_t;

  row_t        qr[$];
  a_t          qa[$];
  logic [7:0]  pw[$];
  logic [7:0]  px[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          stall_k = -1;
  int          stall_n = 0;
  logic [23:0] last_sum;
  logic [7:0]  last_idx;
  row_t        er;
  a_t          ea;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      last_sum = '0;
      last_idx = '0;
    end else begin
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("A_o", int'($signed(A_o)), int'($signed(ea.a)));
        chk("aac", int'(aac), int'(ea.aac));
      end
      if (row_valid) begin
        if (qr.size() == 0) begin
          chk("row_valid_unexpected", 1, 0);
        end else begin
          er = qr.pop_front();
          chk("row_sum", int'($signed(row_sum)), er.sum);
          chk("row_idx", int'(row_idx), er.idx);
          chk("done_with_row", int'(done), int'(er.last));
          chk("row_latency", cyc - er.cyc, 3);
        end
        if (done) done_cnt++;
        last_sum = row_sum;
        last_idx = row_idx;
      end else begin
        chk("done_without_row", int'(done), 0);
        chk("row_sum_hold", int'(row_sum), int'(last_sum));
        chk("row_idx_hold", int'(row_idx), int'(last_idx));
      end
    end
  end

  // One clock of stimulus; records the A_o/aac the DUT must show next cycle.
  task automatic step(input bit v, input logic [7:0] w, input logic [7:0] x,
                      input bit st, input logic [7:0] cc, input logic [7:0] cr,
                      input bit exp_aac, output bit acc, output int ecyc);
    a_t e;
    int p;
    @(negedge clk);
    in_valid = v; w_i = w; x_i = x; start = st; cfg_cols = cc; cfg_rows = cr;
    acc = v && in_ready;
    @(posedge clk);
    ecyc = cyc;
    if (acc) begin
      p = int'($signed(w)) * int'($signed(x));
      e.a = p[23:0];
      e.aac = exp_aac;
    end else begin
      e.a = '0;
      e.aac = 1'b1;
    end
    qa.push_back(e);
  endtask

  task automatic idle_cycle();
    bit a;
    int c;
    step(1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'b1, a, c);
  endtask

  task automatic add(input int w, input int x);
    pw.push_back(8'(w));
    px.push_back(8'(x));
  endtask

  task automatic fill_rand(input int n);
    pw.delete(); px.delete();
    for (int i = 0; i < n; i++) add(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic check_reset_outputs();
    chk("rst_A_o", int'(A_o), 0);
    chk("rst_aac", int'(aac), 0);
    chk("rst_row_valid", int'(row_valid), 0);
    chk("rst_row_sum", int'(row_sum), 0);
    chk("rst_row_idx", int'(row_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
  endtask

  // Runs a job over pw/px; sums are formed here from the pairs directly.
  task automatic run_job(input int cc, input int cr, input int stall_pct, input int abort_at);
    int  ncols, nrows, k, sum, ns, c0, d0, n;
    bit  a, st;
    row_t r;
    ncols = (cc == 0) ? 256 : cc;
    nrows = (cr == 0) ? 256 : cr;
    step(1'b0, 8'($urandom), 8'($urandom), 1'b1, 8'(cc), 8'(cr), 1'b1, a, c0);
    #1;
    chk("busy_after_start", int'(busy), 1);
    chk("in_ready_accum", int'(in_ready), 1);
    k = 0;
    for (int ri = 0; ri < nrows; ri++) begin
      sum = 0;
      for (int ci = 0; ci < ncols; ci++) begin
        ns = (k == stall_k) ? stall_n : 0;
        if (int'($urandom_range(0, 99)) < stall_pct) ns += int'($urandom_range(1, 3));
        for (int s = 0; s < ns; s++) begin
          st = (stall_pct > 0) && ($urandom_range(0, 2) == 0);
          step(1'b0, 8'($urandom), 8'($urandom), st, 8'($urandom), 8'($urandom), 1'b1, a, c0);
        end
        step(1'b1, pw[k], px[k], 1'b0, 8'($urandom), 8'($urandom), ci != 0, a, c0);
        chk("accept", int'(a), 1);
        sum += int'($signed(pw[k])) * int'($signed(px[k]));
        if (ci == ncols - 1) begin
          r.sum = sum; r.idx = ri; r.last = (ri == nrows - 1); r.cyc = c0;
          qr.push_back(r);
        end
        k++;
        if (k == abort_at) begin
          qa.delete(); qr.delete();
          #2 reset_n = 1'b0;
          #1 check_reset_outputs();
          repeat (2) @(posedge clk);
          @(negedge clk) reset_n = 1'b1;
          repeat (10) idle_cycle();
          return;
        end
      end
    end
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      idle_cycle();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 1, 0);
    #1;
    chk("busy_after_done", int'(busy), 0);
    chk("in_ready_idle", int'(in_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    w_i = '0; x_i = '0; cfg_cols = '0; cfg_rows = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) reset_n = 1'b1;
    repeat (2) idle_cycle();

    pw.delete(); px.delete();
    add(1, 2); add(3, 4); add(-5, 6); add(7, -8);
    run_job(4, 1, 0, -1);

    pw.delete(); px.delete();
    add(10, 10); add(10, 10); add(10, 10); add(-1, 1); add(-1, 1); add(-1, 1);
    stall_k = 1; stall_n = 2;
    run_job(3, 2, 0, -1);
    stall_k = -1; stall_n = 0;

    pw.delete(); px.delete();
    for (int i = 0; i < 256; i++) add(-128, -128);
    run_job(0, 1, 0, -1);

    pw.delete(); px.delete();
    add(2, 3); add(4, 5); add(-6, 7);
    run_job(1, 3, 0, -1);

    fill_rand(15);
    run_job(5, 3, 60, -1);

    fill_rand(12);
    run_job(6, 2, 0, 8);
    fill_rand(8);
    run_job(4, 2, 20, -1);

    for (int j = 0; j < 6; j++) begin
      int c, r;
      c = int'($urandom_range(1, 12));
      r = int'($urandom_range(1, 5));
      fill_rand(c * r);
      run_job(c, r, 25, -1);
    end

    repeat (6) idle_cycle();
    chk("rows_outstanding", qr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
